calc_port_driver: RTL and testbench
===================================

CALC_PORT_DRIVER -- requirements
Module: calc_port_driver

Interface
REQ-001 Parameter MAX_OUT, default 4, legal 1..4: maximum outstanding commands on this port.
REQ-002 Clocking is decided: one clock; reset is asynchronous and active-low.
REQ-003 c_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer offers a command.
REQ-006 in_ready  output  1  driver accepts the offered command this cycle.
REQ-007 in_cmd  input  4  calc2 command code.
REQ-008 in_op1, in_op2  input  32 each  operands 1 and 2.
REQ-009 req_cmd_in  output  4  to calc2 reqN_cmd_in.
REQ-010 req_data_in  output  32  to calc2 reqN_data_in.
REQ-011 req_tag_in  output  2  to calc2 reqN_tag_in.
REQ-012 out_resp, out_tag  input  2, 2  from calc2 out_respN/out_tagN; out_data  input  32  from out_dataN.
REQ-013 rsp_valid  output  1  one-cycle pulse, completed response.
REQ-014 rsp_resp, rsp_tag  output  2, 2; rsp_cmd  output  4; rsp_data  output  32  response fields and original command.
REQ-015 outstanding  output  3  count of tags in flight.
REQ-016 spurious_err  output  1  sticky flag: response on a tag not in flight.

Function
REQ-017 Handshake: transfer occurs when in_valid & in_ready are high at a rising edge; in_valid may assert regardless of in_ready.
REQ-018 in_ready = (state == IDLE) & (outstanding < MAX_OUT), computed from registered state only.
REQ-019 in_cmd == 0 is accepted and discarded: no tag allocated, no bus activity, state stays IDLE.
REQ-020 Non-zero accepted command: allocate lowest-numbered free tag; capture cmd, op1, op2; record cmd in a per-tag table; set tag busy.
REQ-021 FSM IDLE -> OP1 on non-zero accept; OP1 -> OP2 unconditionally; OP2 -> IDLE unconditionally.
REQ-022 OP1 cycle: req_cmd_in = cmd, req_data_in = op1, req_tag_in = tag; begins the cycle after acceptance (1-cycle latency).
REQ-023 OP2 cycle: req_cmd_in = 0, req_data_in = op2, req_tag_in = tag.
REQ-024 IDLE: req_cmd_in = 0, req_data_in = 0, req_tag_in = 0; all req_* outputs registered.
REQ-025 Maximum issue rate: one command per 3 cycles.
REQ-026 Response capture: out_resp != 0 with out_tag busy -> next cycle rsp_valid = 1, rsp_resp/rsp_tag/rsp_data copied, rsp_cmd from tag table; tag freed at the same edge.
REQ-027 Response on a non-busy tag: spurious_err set (sticky until reset), rsp_valid stays 0, no state change.
REQ-028 rsp_* fields hold last value while rsp_valid = 0; no backpressure on the response side.
REQ-029 Simultaneous allocate and free in one edge: both take effect; outstanding = old + 1 - 1; a freed tag is allocatable from the following cycle.
REQ-030 outstanding equals the popcount of the busy bitmap and never exceeds MAX_OUT.
REQ-031 Response may arrive for a tag while another command is in OP1/OP2; the two paths are independent.

Reset
REQ-032 reset low asynchronously clears: state = IDLE, busy bitmap = 0, outstanding = 0, all req_* = 0, rsp_valid = 0, rsp_* = 0, spurious_err = 0, in_ready = 0 while reset is low.
REQ-033 Reset mid-OP1/OP2 aborts the command; its tag is freed; the command is not replayed.
REQ-034 First acceptance is possible on the first rising edge after reset deasserts.

Verification
REQ-035 Single add: in_cmd=1, op1=5, op2=7 accepted at cycle 0 -> cycle 1 req=(1,5,tag0), cycle 2 req=(0,7,tag0); out_resp=1, out_data=12, out_tag=0 -> next cycle rsp_valid=1, rsp_cmd=1, rsp_data=12, outstanding 1 -> 0.
REQ-036 Saturation: MAX_OUT=4, four commands issued with no responses -> tags 0,1,2,3 in order; in_ready=0 with outstanding=4; respond tag 2 -> in_ready=1 next cycle; next command uses tag 2.
REQ-037 Out-of-order completion: responses for tags 3,0,1 -> rsp_cmd matches each original command; outstanding decrements each time.
REQ-038 Spurious response out_resp=1, out_tag=1 with nothing in flight -> spurious_err=1 held, rsp_valid=0.
REQ-039 NOP and reset: in_cmd=0 accepted -> no req activity, outstanding unchanged; assert reset during OP2 -> req_* = 0 immediately, outstanding=0, in_ready=1 on the first edge after release.

Source files
------------

// File: rtl/calc_port_driver.sv
`default_nettype none
// calc_port_driver: issues tagged two-beat commands to one calc2 request port and
// matches the responses back to their commands. Rev 1.0
module calc_port_driver #(
  parameter int MAX_OUT = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_cmd,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  output logic [3:0]  req_cmd_in,
  output logic [31:0] req_data_in,
  output logic [1:0]  req_tag_in,
  input  logic [1:0]  out_resp,
  input  logic [1:0]  out_tag,
  input  logic [31:0] out_data,
  output logic        rsp_valid,
  output logic [1:0]  rsp_resp,
  output logic [1:0]  rsp_tag,
  output logic [3:0]  rsp_cmd,
  output logic [31:0] rsp_data,
  output logic [2:0]  outstanding,
  output logic        spurious_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP1  = 2'd1,
    S_OP2  = 2'd2
  } state_t;

  state_t          r_state;
  logic [3:0]      r_busy;
  logic [3:0][3:0] r_cmd_tbl;
  logic [1:0]      r_tag;
  logic [31:0]     r_op2;

  logic [2:0]      w_count;
  logic [1:0]      w_free_tag;
  logic            w_accept;
  logic            w_alloc;
  logic            w_resp_hit;
  logic            w_resp_spur;
  logic [3:0]      w_alloc_mask;
  logic [3:0]      w_free_mask;

  always_comb begin
    w_count = '0;
    for (int i = 0; i < 4; i++) begin
      w_count = w_count + {2'b00, r_busy[i]};
    end
  end

  // Scanning downward leaves the lowest-numbered free tag selected.
  always_comb begin
    w_free_tag = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_tag = 2'(i);
      end
    end
  end

  assign outstanding = w_count;
  assign in_ready    = reset & (r_state == S_IDLE) & (w_count < 3'(MAX_OUT));
  assign w_accept    = in_valid & in_ready;
  assign w_alloc     = w_accept & (in_cmd != 4'd0);
  assign w_resp_hit  = (out_resp != 2'd0) &  r_busy[out_tag];
  assign w_resp_spur = (out_resp != 2'd0) & ~r_busy[out_tag];

  // The allocated tag is free and the responding tag is busy, so the masks never overlap.
  assign w_alloc_mask = w_alloc    ? (4'b0001 << w_free_tag) : 4'b0000;
  assign w_free_mask  = w_resp_hit ? (4'b0001 << out_tag)    : 4'b0000;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_busy       <= '0;
      r_cmd_tbl    <= '0;
      r_tag        <= '0;
      r_op2        <= '0;
      req_cmd_in   <= '0;
      req_data_in  <= '0;
      req_tag_in   <= '0;
      rsp_valid    <= 1'b0;
      rsp_resp     <= '0;
      rsp_tag      <= '0;
      rsp_cmd      <= '0;
      rsp_data     <= '0;
      spurious_err <= 1'b0;
    end else begin
      r_busy <= (r_busy | w_alloc_mask) & ~w_free_mask;

      case (r_state)
        S_IDLE: begin
          if (w_alloc) begin
            r_state               <= S_OP1;
            r_tag                 <= w_free_tag;
            r_op2                 <= in_op2;
            r_cmd_tbl[w_free_tag] <= in_cmd;
            req_cmd_in            <= in_cmd;
            req_data_in           <= in_op1;
            req_tag_in            <= w_free_tag;
          end else begin
            req_cmd_in  <= '0;
            req_data_in <= '0;
            req_tag_in  <= '0;
          end
        end
        S_OP1: begin
          r_state     <= S_OP2;
          req_cmd_in  <= '0;
          req_data_in <= r_op2;
          req_tag_in  <= r_tag;
        end
        default: begin
          r_state     <= S_IDLE;
          req_cmd_in  <= '0;
          req_data_in <= '0;
          req_tag_in  <= '0;
        end
      endcase

      rsp_valid <= w_resp_hit;
      if (w_resp_hit) begin
        rsp_resp <= out_resp;
        rsp_tag  <= out_tag;
        rsp_data <= out_data;
        rsp_cmd  <= r_cmd_tbl[out_tag];
      end
      if (w_resp_spur) begin
        spurious_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calc_port_driver.sv
`default_nettype none
// tb_calc_port_driver: directed, self-checking bench for calc_port_driver. Rev 1.0
module tb_calc_port_driver;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_op1 = '0;
  logic [31:0] in_op2 = '0;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp = '0;
  logic [1:0]  out_tag = '0;
  logic [31:0] out_data = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_resp;
  logic [1:0]  rsp_tag;
  logic [3:0]  rsp_cmd;
  logic [31:0] rsp_data;
  logic [2:0]  outstanding;
  logic        spurious_err;

  int total = 0;
  int bad   = 0;

  calc_port_driver #(.MAX_OUT(4)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cmd      (in_cmd),
    .in_op1      (in_op1),
    .in_op2      (in_op2),
    .req_cmd_in  (req_cmd_in),
    .req_data_in (req_data_in),
    .req_tag_in  (req_tag_in),
    .out_resp    (out_resp),
    .out_tag     (out_tag),
    .out_data    (out_data),
    .rsp_valid   (rsp_valid),
    .rsp_resp    (rsp_resp),
    .rsp_tag     (rsp_tag),
    .rsp_cmd     (rsp_cmd),
    .rsp_data    (rsp_data),
    .outstanding (outstanding),
    .spurious_err(spurious_err)
  );

  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // Offers one command, holds it for the accept edge, then lets OP1/OP2 run out.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       output logic [1:0] tag);
    in_valid = 1'b1; in_cmd = cmd; in_op1 = a; in_op2 = b;
    tick();
    in_valid = 1'b0; in_cmd = '0;
    tag = req_tag_in;
    tick();
    tick();
  endtask

  task automatic respond(input logic [1:0] tag, input logic [31:0] data);
    out_resp = 2'd1; out_tag = tag; out_data = data;
    tick();
    out_resp = '0; out_tag = '0; out_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding); end
    total++; if ({req_cmd_in, req_data_in, req_tag_in} !== 38'd0) begin bad++; $display("FAIL reset_req got=%h/%h/%h exp=0", req_cmd_in, req_data_in, req_tag_in); end
    total++; if ({rsp_valid, spurious_err} !== 2'b00) begin bad++; $display("FAIL reset_rsp got=%b exp=00", {rsp_valid, spurious_err}); end
    #3 reset = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_single_add();
    in_valid = 1'b1; in_cmd = 4'd1; in_op1 = 32'd5; in_op2 = 32'd7;
    tick();
    in_valid = 1'b0; in_cmd = '0;
    total++; if ({req_cmd_in, req_data_in, req_tag_in} !== {4'd1, 32'd5, 2'd0}) begin bad++; $display("FAIL add_op1 got=%0d/%0d/%0d exp=1/5/0", req_cmd_in, req_data_in, req_tag_in); end
    total++; if (outstanding !== 3'd1) begin bad++; $display("FAIL add_outstanding got=%0d exp=1", outstanding); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL add_busy_ready got=%0b exp=0", in_ready); end
    tick();
    total++; if ({req_cmd_in, req_data_in, req_tag_in} !== {4'd0, 32'd7, 2'd0}) begin bad++; $display("FAIL add_op2 got=%0d/%0d/%0d exp=0/7/0", req_cmd_in, req_data_in, req_tag_in); end
    respond(2'd0, 32'd12);
    total++; if ({req_cmd_in, req_data_in} !== 36'd0) begin bad++; $display("FAIL add_idle_req got=%0d/%0d exp=0/0", req_cmd_in, req_data_in); end
    total++; if ({rsp_valid, rsp_resp, rsp_tag, rsp_cmd, rsp_data} !== {1'b1, 2'd1, 2'd0, 4'd1, 32'd12}) begin bad++; $display("FAIL add_rsp got=%0b/%0d/%0d/%0d/%0d exp=1/1/0/1/12", rsp_valid, rsp_resp, rsp_tag, rsp_cmd, rsp_data); end
    total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL add_done_outstanding got=%0d exp=0", outstanding); end
    tick();
    total++; if ({rsp_valid, rsp_data} !== {1'b0, 32'd12}) begin bad++; $display("FAIL add_rsp_hold got=%0b/%0d exp=0/12", rsp_valid, rsp_data); end
  endtask

  task automatic test_saturation();
    logic [1:0] tag;
    for (int i = 0; i < 4; i++) begin
      issue(4'(i + 2), 32'(100 + i), 32'(200 + i), tag);
      total++; if (tag !== 2'(i)) begin bad++; $display("FAIL sat_tag%0d got=%0d exp=%0d", i, tag, i); end
    end
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL sat_outstanding got=%0d exp=4", outstanding); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sat_ready got=%0b exp=0", in_ready); end
    respond(2'd2, 32'hABCD);
    total++; if ({rsp_valid, rsp_cmd} !== {1'b1, 4'd4}) begin bad++; $display("FAIL sat_rsp2 got=%0b/%0d exp=1/4", rsp_valid, rsp_cmd); end
    total++; if ({in_ready, outstanding} !== {1'b1, 3'd3}) begin bad++; $display("FAIL sat_reopen got=%0b/%0d exp=1/3", in_ready, outstanding); end
    issue(4'd6, 32'd1, 32'd2, tag);
    total++; if (tag !== 2'd2) begin bad++; $display("FAIL sat_reuse_tag got=%0d exp=2", tag); end
    total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL sat_refill got=%0d exp=4", outstanding); end
  endtask

  task automatic test_out_of_order();
    logic [1:0] tags [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic [3:0] cmds [4] = '{4'd5, 4'd2, 4'd3, 4'd6};
    for (int i = 0; i < 4; i++) begin
      respond(tags[i], 32'(i + 40));
      total++; if ({rsp_valid, rsp_tag, rsp_cmd, rsp_data} !== {1'b1, tags[i], cmds[i], 32'(i + 40)}) begin bad++; $display("FAIL ooo_rsp%0d got=%0b/%0d/%0d/%0d exp=1/%0d/%0d/%0d", i, rsp_valid, rsp_tag, rsp_cmd, rsp_data, tags[i], cmds[i], i + 40); end
      total++; if (outstanding !== 3'(3 - i)) begin bad++; $display("FAIL ooo_outstanding%0d got=%0d exp=%0d", i, outstanding, 3 - i); end
    end
  endtask

  task automatic test_spurious();
    respond(2'd1, 32'd99);
    total++; if ({rsp_valid, spurious_err} !== 2'b01) begin bad++; $display("FAIL spur_flag got=%b exp=01", {rsp_valid, spurious_err}); end
    tick(); tick();
    total++; if ({spurious_err, outstanding} !== {1'b1, 3'd0}) begin bad++; $display("FAIL spur_sticky got=%0b/%0d exp=1/0", spurious_err, outstanding); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] tag;
    issue(4'd7, 32'd3, 32'd4, tag);
    in_valid = 1'b1; in_cmd = 4'd8; in_op1 = 32'd11; in_op2 = 32'd22;
    out_resp = 2'd2; out_tag = 2'd0; out_data = 32'd77;
    tick();
    in_valid = 1'b0; in_cmd = '0; out_resp = '0; out_tag = '0; out_data = '0;
    total++; if ({rsp_valid, rsp_resp, rsp_cmd, rsp_data} !== {1'b1, 2'd2, 4'd7, 32'd77}) begin bad++; $display("FAIL b2b_rsp got=%0b/%0d/%0d/%0d exp=1/2/7/77", rsp_valid, rsp_resp, rsp_cmd, rsp_data); end
    total++; if ({req_cmd_in, req_tag_in, outstanding} !== {4'd8, 2'd1, 3'd1}) begin bad++; $display("FAIL b2b_alloc got=%0d/%0d/%0d exp=8/1/1", req_cmd_in, req_tag_in, outstanding); end
    respond(2'd1, 32'd5);
    total++; if ({req_data_in, req_tag_in, rsp_cmd, outstanding} !== {32'd22, 2'd1, 4'd8, 3'd0}) begin bad++; $display("FAIL b2b_op2_resp got=%0d/%0d/%0d/%0d exp=22/1/8/0", req_data_in, req_tag_in, rsp_cmd, outstanding); end
    tick();
  endtask

  task automatic test_nop_and_reset();
    in_valid = 1'b1; in_cmd = 4'd0; in_op1 = 32'hDEAD; in_op2 = 32'hBEEF;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL nop_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++; if ({req_cmd_in, req_data_in, outstanding, in_ready} !== {4'd0, 32'd0, 3'd0, 1'b1}) begin bad++; $display("FAIL nop_quiet got=%0d/%0h/%0d/%0b exp=0/0/0/1", req_cmd_in, req_data_in, outstanding, in_ready); end
    in_valid = 1'b1; in_cmd = 4'd9; in_op1 = 32'd1; in_op2 = 32'd2;
    tick();
    in_valid = 1'b0; in_cmd = '0;
    tick();
    total++; if (req_data_in !== 32'd2) begin bad++; $display("FAIL rst_pre_op2 got=%0d exp=2", req_data_in); end
    reset = 1'b0;
    #1;
    total++; if ({req_cmd_in, req_data_in, req_tag_in, outstanding, in_ready} !== 42'd0) begin bad++; $display("FAIL rst_abort got=%0d/%0d/%0d/%0d/%0b exp=0", req_cmd_in, req_data_in, req_tag_in, outstanding, in_ready); end
    tick();
    #2 reset = 1'b1;
    in_valid = 1'b1; in_cmd = 4'd3; in_op1 = 32'd33; in_op2 = 32'd44;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b exp=1", in_ready); end
    tick();
    in_valid = 1'b0; in_cmd = '0;
    total++; if ({req_cmd_in, req_data_in, req_tag_in, outstanding} !== {4'd3, 32'd33, 2'd0, 3'd1}) begin bad++; $display("FAIL rst_first_accept got=%0d/%0d/%0d/%0d exp=3/33/0/1", req_cmd_in, req_data_in, req_tag_in, outstanding); end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_saturation();
    test_out_of_order();
    test_spurious();
    test_back_to_back();
    test_nop_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
